// File: rtl/cm0_dap_pkg.sv
// Shared definitions for the DP<->AP access channel: FSM encoding and the
// bit layout of both domain-crossing buses.
package cm0_dap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } apif_state_e;

    localparam int unsigned DP_TO_AP_W   = 38;
    localparam int unsigned AP_TO_DP_W   = 34;

    // cm0_dap_dp_to_ap = {rnw, regaddr, data, req}
    localparam int unsigned D2A_REQ_BIT  = 0;
    localparam int unsigned D2A_DATA_LSB = 1;
    localparam int unsigned D2A_DATA_W   = 32;
    localparam int unsigned D2A_ADDR_LSB = 33;
    localparam int unsigned D2A_ADDR_W   = 4;
    localparam int unsigned D2A_RNW_BIT  = 37;

    // cm0_dap_ap_to_dp = {data, err, ack}
    localparam int unsigned A2D_ACK_BIT  = 0;
    localparam int unsigned A2D_ERR_BIT  = 1;
    localparam int unsigned A2D_DATA_LSB = 2;
    localparam int unsigned A2D_DATA_W   = 32;

    // Response synthesised locally when no AP is fitted: err=1, data=0.
    localparam logic [AP_TO_DP_W-1:0] NOT_PRESENT_RESP = {32'h0000_0000, 1'b1, 1'b1};

    function automatic logic [DP_TO_AP_W-1:0] pack_dp_to_ap(
        input logic                  rnw,
        input logic [D2A_ADDR_W-1:0] addr,
        input logic [D2A_DATA_W-1:0] data,
        input logic                  req
    );
        return {rnw, addr, data, req};
    endfunction

endpackage

// File: rtl/cm0_dap_sync.sv
// 1-bit two-flop synchroniser, synchronous active-high reset to 0.
module cm0_dap_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/cm0_dap_dp_apif.sv
// DP-side initiator of the DP->AP four-phase req/ack channel.
// Define CM0_DAP_DP_APIF_ACKSYNC_EN to pass raw ack through a 2-flop synchroniser.
module cm0_dap_dp_apif
    import cm0_dap_pkg::*;
#(
    parameter bit PRESENT = 1'b1
) (
    input  logic                  dclk,
    input  logic                  dpreset,
    input  logic                  ap_acc_req,
    input  logic                  ap_acc_rnw,
    input  logic [3:0]            ap_acc_addr,
    input  logic [31:0]           ap_acc_wdata,
    input  logic                  ap_abort,
    output logic                  ap_acc_busy,
    output logic                  ap_acc_done,
    output logic [31:0]           ap_acc_rdata,
    output logic                  ap_acc_err,
    output logic [DP_TO_AP_W-1:0] cm0_dap_dp_to_ap,
    input  logic [AP_TO_DP_W-1:0] cm0_dap_ap_to_dp
);

    apif_state_e state_q, state_d;
    logic        req_q, req_d;
    logic        rnw_q, rnw_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        abort_q, abort_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        ack_raw;
    logic        ack_s;
    logic        ack_eff;
    logic        discard;

    assign ack_raw = cm0_dap_ap_to_dp[A2D_ACK_BIT];

`ifdef CM0_DAP_DP_APIF_ACKSYNC_EN
    cm0_dap_sync u_ack_sync (
        .clk_i (dclk),
        .rst_i (dpreset),
        .d_i   (ack_raw),
        .q_o   (ack_s)
    );
`else
    assign ack_s = ack_raw;
`endif

    // Without an AP the handshake never starts, so ack is ignored entirely.
    assign ack_eff = PRESENT ? ack_s : 1'b0;
    // An abort arriving in the same cycle as ack_s still discards the result.
    assign discard = abort_q | ap_abort;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        abort_d = abort_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ap_acc_req) begin
                    abort_d = 1'b0;
                    if (PRESENT) begin
                        rnw_d   = ap_acc_rnw;
                        addr_d  = ap_acc_addr;
                        wdata_d = ap_acc_wdata;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        rdata_d = NOT_PRESENT_RESP[A2D_DATA_LSB +: A2D_DATA_W];
                        err_d   = NOT_PRESENT_RESP[A2D_ERR_BIT];
                        done_d  = 1'b1;
                        state_d = ST_REL;
                    end
                end
            end
            ST_REQ: begin
                if (ap_abort) begin
                    abort_d = 1'b1;
                end
                if (ack_eff) begin
                    req_d   = 1'b0;
                    state_d = ST_REL;
                    if (!discard) begin
                        done_d = 1'b1;
                        err_d  = cm0_dap_ap_to_dp[A2D_ERR_BIT];
                        if (rnw_q) begin
                            rdata_d = cm0_dap_ap_to_dp[A2D_DATA_LSB +: A2D_DATA_W];
                        end
                    end
                end
            end
            ST_REL: begin
                if (ap_abort) begin
                    abort_d = 1'b1;
                end
                if (!ack_eff) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (dpreset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            abort_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign ap_acc_busy      = (state_q != ST_IDLE);
    assign ap_acc_done      = done_q;
    assign ap_acc_rdata     = rdata_q;
    assign ap_acc_err       = err_q;
    assign cm0_dap_dp_to_ap = PRESENT ? pack_dp_to_ap(rnw_q, addr_q, wdata_q, req_q) : '0;

endmodule

// File: tb/tb_cm0_dap_dp_apif.sv
// Scoreboard bench for cm0_dap_dp_apif: AP behavioural model plus done monitor.
module tb_cm0_dap_dp_apif;

`ifdef CM0_DAP_DP_APIF_ACKSYNC_EN
    localparam int unsigned N = 2;
`else
    localparam int unsigned N = 0;
`endif

    logic        dclk    = 1'b0;
    logic        dpreset = 1'b1;
    logic        req     = 1'b0;
    logic        rnw     = 1'b0;
    logic [3:0]  addr    = '0;
    logic [31:0] wdata   = '0;
    logic        abort   = 1'b0;
    logic [33:0] a2d     = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [37:0] d2a;

    logic        np_req  = 1'b0;
    logic [33:0] np_a2d  = '0;
    logic        np_busy, np_done, np_err;
    logic [31:0] np_rdata;
    logic [37:0] np_d2a;

    cm0_dap_dp_apif #(.PRESENT(1'b1)) u_dut (
        .dclk             (dclk),
        .dpreset          (dpreset),
        .ap_acc_req       (req),
        .ap_acc_rnw       (rnw),
        .ap_acc_addr      (addr),
        .ap_acc_wdata     (wdata),
        .ap_abort         (abort),
        .ap_acc_busy      (busy),
        .ap_acc_done      (done),
        .ap_acc_rdata     (rdata),
        .ap_acc_err       (err),
        .cm0_dap_dp_to_ap (d2a),
        .cm0_dap_ap_to_dp (a2d)
    );

    cm0_dap_dp_apif #(.PRESENT(1'b0)) u_np (
        .dclk             (dclk),
        .dpreset          (dpreset),
        .ap_acc_req       (np_req),
        .ap_acc_rnw       (rnw),
        .ap_acc_addr      (addr),
        .ap_acc_wdata     (wdata),
        .ap_abort         (abort),
        .ap_acc_busy      (np_busy),
        .ap_acc_done      (np_done),
        .ap_acc_rdata     (np_rdata),
        .ap_acc_err       (np_err),
        .cm0_dap_dp_to_ap (np_d2a),
        .cm0_dap_ap_to_dp (np_a2d)
    );

    always #5 dclk = ~dclk;

    int unsigned cyc = 0;
    always @(posedge dclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] rdata_m    = '0;
    logic        err_m      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    // One complete access against the AP model: ack raised t_dly cycles into
    // REQ, optional abort/colliding request at given REQ-relative cycles (-1 = none).
    task automatic access(input logic t_rnw, input logic [3:0] t_addr, input logic [31:0] t_wdata,
                          input logic [31:0] t_apdata, input logic t_aperr,
                          input int t_dly, input int t_abort, input int t_coll);
        logic [37:0] exp_bus;
        int unsigned rise;
        int unsigned drop;
        int          k;
        bit          discard;
        exp_t        e;
        rise = 0;
        rnw = t_rnw; addr = t_addr; wdata = t_wdata; req = 1'b1;
        step();
        req = 1'b0; rnw = 1'($urandom); addr = 4'($urandom); wdata = $urandom;
        exp_bus = {t_rnw, t_addr, t_wdata, 1'b1};
        check("busy_on_req", busy, 1);
        discard = (t_abort >= 0) && (t_abort <= t_dly + int'(N));
        k = 0;
        while (k < 60) begin
            check("bus_in_req", d2a, exp_bus);
            if (k == t_dly) begin
                a2d  = {t_apdata, t_aperr, 1'b1};
                rise = cyc;
                if (!discard) begin
                    err_m = t_aperr;
                    if (t_rnw) rdata_m = t_apdata;
                    e.rdata = rdata_m; e.err = err_m; e.due = rise + N + 1;
                    sb.push_back(e);
                end
            end
            abort = (k == t_abort);
            if (k == t_coll) begin
                req = 1'b1; wdata = '0; rnw = ~t_rnw; addr = ~t_addr;
            end
            step();
            k++;
            abort = 1'b0; req = 1'b0;
            if (!d2a[0]) break;
        end
        check("req_drop", d2a[0], 0);
        check("req_fall_cycle", cyc, rise + N + 1);
        exp_bus[0] = 1'b0;
        check("bus_in_rel", d2a, exp_bus);
        repeat ($urandom_range(0, 3)) begin
            step();
            check("bus_rel_hold", d2a, exp_bus);
        end
        a2d  = {$urandom, 2'b00};
        drop = cyc;
        k = 0;
        while (busy && k < 40) begin
            step();
            k++;
        end
        check("busy_drop", busy, 0);
        check("idle_cycle", cyc, drop + N + 1);
        check("no_pending_done", sb.size(), 0);
        check("rdata_hold", rdata, rdata_m);
        check("err_hold", err, err_m);
    endtask

    initial begin
        fork
            forever begin
                @(negedge dclk);
                if (!dpreset && done) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", done, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("done_rdata", rdata, e.rdata);
                        check("done_err", err, e.err);
                        check("done_cycle", cyc, e.due);
                    end
                end
            end
        join_none

        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_bus", d2a, 0);
        check("rst_np_bus", np_d2a, 0);
        check("rst_np_err", np_err, 0);
        dpreset = 1'b0;
        step();

        // Write: rdata must not change.
        access(1'b0, 4'h1, 32'hDEADBEEF, 32'h0BAD_F00D, 1'b0, 5, -1, -1);
        check("write_rdata_unchanged", rdata, 32'h0);
        check("write_err", err, 0);

        // Read with error, held through idle cycles.
        access(1'b1, 4'hC, 32'h0, 32'h12345678, 1'b1, 3, -1, -1);
        repeat (10) begin
            step();
            check("read_rdata_held", rdata, 32'h12345678);
            check("read_err_held", err, 1);
        end

        // Abort two cycles into REQ, and abort coinciding with ack_s.
        access(1'b1, 4'h3, 32'h0, 32'hA5A5_5A5A, 1'b0, 5, 2, -1);
        access(1'b0, 4'h4, 32'h1111_2222, 32'h0, 1'b0, 2, 2 + int'(N), -1);
        check("abort_rdata_kept", rdata, 32'h12345678);
        check("abort_err_kept", err, 1);

        // Colliding request during REQ.
        access(1'b0, 4'h7, 32'hCAFEF00D, 32'h0, 1'b0, 4, -1, 1);

        // Reset in the middle of REQ with ack already raised.
        rnw = 1'b1; addr = 4'h5; wdata = $urandom; req = 1'b1;
        step();
        req = 1'b0;
        step();
        check("rst_mid_req_active", d2a[0], 1);
        a2d = {$urandom, 2'b01};
        dpreset = 1'b1;
        step();
        dpreset = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_bus", d2a, 0);
        rdata_m = '0; err_m = 1'b0;
        a2d = '0;
        repeat (N + 3) step();
        access(1'b1, 4'h9, 32'h0, 32'h7654_3210, 1'b0, 2, -1, -1);

        // No AP fitted.
        repeat (3) begin
            rnw = 1'($urandom); addr = 4'($urandom); wdata = $urandom; np_req = 1'b1;
            step();
            np_req = 1'b0;
            check("np_done", np_done, 1);
            check("np_err", np_err, 1);
            check("np_rdata", np_rdata, 0);
            check("np_bus", np_d2a, 0);
            step();
            check("np_done_single", np_done, 0);
            check("np_idle", np_busy, 0);
            check("np_bus_idle", np_d2a, 0);
        end

        // Randomised traffic.
        for (int i = 0; i < 25; i++) begin
            int dly;
            int ab;
            int co;
            dly = int'($urandom_range(0, 6));
            ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly + int'(N))) : -1;
            co  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly)) : -1;
            access(1'($urandom), 4'($urandom), $urandom, $urandom, 1'($urandom), dly, ab, co);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        check("final_queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
